// File: rtl/dram_axi_master.sv
// Single-outstanding AXI-style master that maps an 8-bit record index onto a DRAM
// byte address and performs one 64-bit read or write per core request.
module dram_axi_master #(
  parameter int                ADDR_W    = 17,
  parameter int                DATA_W    = 64,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h10000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  input  logic              req_write,
  input  logic [7:0]        req_idx,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              AR_VALID,
  output logic [ADDR_W-1:0] AR_ADDR,
  input  logic              AR_READY,
  input  logic              R_VALID,
  input  logic [DATA_W-1:0] R_DATA,
  input  logic [1:0]        R_RESP,
  output logic              R_READY,
  output logic              AW_VALID,
  output logic [ADDR_W-1:0] AW_ADDR,
  input  logic              AW_READY,
  output logic              W_VALID,
  output logic [DATA_W-1:0] W_DATA,
  input  logic              W_READY,
  input  logic              B_VALID,
  input  logic [1:0]        B_RESP,
  output logic              B_READY
);

  typedef enum logic [2:0] {IDLE, RD_A, RD_D, WR_AW, WR_B, DONE} state_e;

  state_e              state_q, state_d;
  logic                aw_done_q, aw_done_d, w_done_q, w_done_d;
  logic [ADDR_W-1:0]   ar_addr_q, ar_addr_d, aw_addr_q, aw_addr_d;
  logic [DATA_W-1:0]   w_data_q, w_data_d, rdata_q, rdata_d;
  logic                err_d;
  logic                req_ready_q, ar_valid_q, r_ready_q, aw_valid_q, w_valid_q;
  logic                b_ready_q, rsp_valid_q, rsp_err_q;
  logic [ADDR_W-1:0]   req_addr;

  // Record stride is 8 bytes; the sum deliberately wraps within ADDR_W bits.
  assign req_addr = BASE_ADDR + ADDR_W'({req_idx, 3'b000});

  always_comb begin
    state_d   = state_q;
    aw_done_d = aw_done_q;
    w_done_d  = w_done_q;
    ar_addr_d = ar_addr_q;
    aw_addr_d = aw_addr_q;
    w_data_d  = w_data_q;
    rdata_d   = rdata_q;
    err_d     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (req_valid && req_ready_q) begin
          if (req_write) begin
            aw_addr_d = req_addr;
            w_data_d  = req_wdata;
            aw_done_d = 1'b0;
            w_done_d  = 1'b0;
            state_d   = WR_AW;
          end else begin
            ar_addr_d = req_addr;
            state_d   = RD_A;
          end
        end
      end
      RD_A: if (ar_valid_q && AR_READY) state_d = RD_D;
      RD_D: begin
        if (r_ready_q && R_VALID) begin
          rdata_d = R_DATA;
          err_d   = (R_RESP != 2'b00);
          state_d = DONE;
        end
      end
      // Address and data channels complete independently, possibly in the same cycle.
      WR_AW: begin
        if (aw_valid_q && AW_READY) aw_done_d = 1'b1;
        if (w_valid_q && W_READY)   w_done_d  = 1'b1;
        if (aw_done_d && w_done_d)  state_d   = WR_B;
      end
      WR_B: begin
        if (b_ready_q && B_VALID) begin
          err_d   = (B_RESP != 2'b00);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Every handshake output is the registered decode of the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      ar_addr_q   <= '0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      rdata_q     <= '0;
      req_ready_q <= 1'b0;
      ar_valid_q  <= 1'b0;
      r_ready_q   <= 1'b0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      ar_addr_q   <= ar_addr_d;
      aw_addr_q   <= aw_addr_d;
      w_data_q    <= w_data_d;
      rdata_q     <= rdata_d;
      req_ready_q <= (state_d == IDLE);
      ar_valid_q  <= (state_d == RD_A);
      r_ready_q   <= (state_d == RD_D);
      aw_valid_q  <= (state_d == WR_AW) && !aw_done_d;
      w_valid_q   <= (state_d == WR_AW) && !w_done_d;
      b_ready_q   <= (state_d == WR_B);
      rsp_valid_q <= (state_d == DONE);
      rsp_err_q   <= err_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rdata_q;
  assign rsp_err   = rsp_err_q;
  assign AR_VALID  = ar_valid_q;
  assign AR_ADDR   = ar_addr_q;
  assign R_READY   = r_ready_q;
  assign AW_VALID  = aw_valid_q;
  assign AW_ADDR   = aw_addr_q;
  assign W_VALID   = w_valid_q;
  assign W_DATA    = w_data_q;
  assign B_READY   = b_ready_q;

endmodule

// File: tb/tb_dram_axi_master.sv
// Bench for dram_axi_master: a DRAM slave with configurable READY/response timing,
// a record-level reference model feeding a response scoreboard, and directed corner cases.
module tb_dram_axi_master;

  logic        clk = 1'b0;
  logic        rstN;
  logic        reqValid, reqWrite, reqReady, rspValid, rspErr;
  logic [7:0]  reqIdx;
  logic [63:0] reqWdata, rspRdata;
  logic        arValid, arReady, rValid, rReady, awValid, awReady, wValid, wReady, bValid, bReady;
  logic [16:0] arAddr, awAddr;
  logic [63:0] rData, wData;
  logic [1:0]  rResp, bResp;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          expCycle;
  } rsp_t;

  rsp_t        scoreQ[$];
  logic [16:0] expArQ[$], expAwQ[$];
  logic [63:0] expWQ[$];
  logic [63:0] refMem[logic [16:0]];
  logic [63:0] dramMem[logic [16:0]];
  logic [63:0] lastRdata = '0;
  int          compared = 0, mismatched = 0, posCount = 0;
  int          cfgArDly = 0, cfgAwDly = 0, cfgWDly = 0, cfgRLat = 0, cfgBLat = 0;
  logic [1:0]  cfgRResp = 2'b00, cfgBResp = 2'b00;

  dram_axi_master dut (
    .clk(clk), .rst_n(rstN),
    .req_valid(reqValid), .req_write(reqWrite), .req_idx(reqIdx), .req_wdata(reqWdata),
    .req_ready(reqReady), .rsp_valid(rspValid), .rsp_rdata(rspRdata), .rsp_err(rspErr),
    .AR_VALID(arValid), .AR_ADDR(arAddr), .AR_READY(arReady),
    .R_VALID(rValid), .R_DATA(rData), .R_RESP(rResp), .R_READY(rReady),
    .AW_VALID(awValid), .AW_ADDR(awAddr), .AW_READY(awReady),
    .W_VALID(wValid), .W_DATA(wData), .W_READY(wReady),
    .B_VALID(bValid), .B_RESP(bResp), .B_READY(bReady)
  );

  always #5 clk = ~clk;
  always @(posedge clk) posCount <= posCount + 1;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    compared++;
    mismatched++;
    $display("[TB] FAIL %s: condition not reached at %0t", name, $time);
  endtask

  function automatic logic [16:0] modelAddr(input int idx);
    return 17'((32'h10000 + idx * 8) % 131072);
  endfunction

  function automatic logic [63:0] initWord(input logic [16:0] a);
    return {32'hC0DE_0000 | {15'd0, a}, ~{15'd0, a}};
  endfunction

  function automatic logic [63:0] refRead(input logic [16:0] a);
    return refMem.exists(a) ? refMem[a] : initWord(a);
  endfunction

  function automatic logic [63:0] dramRead(input logic [16:0] a);
    return dramMem.exists(a) ? dramMem[a] : initWord(a);
  endfunction

  // DRAM slave: drives READY/response signals at negedges and watches the master's protocol.
  initial begin : slave
    logic hsAr, hsR, hsAw, hsW, hsB, prevArV, prevAwV, prevWV, rPend, bPend, awGot, wGot;
    logic [16:0] prevArA, prevAwA, rAddr, wrAddr;
    logic [63:0] prevWD, wrData;
    int arCnt, awCnt, wCnt, rWait, bWait;
    {arReady, rValid, awReady, wReady, bValid} = '0;
    rData = '0; rResp = '0; bResp = '0;
    {hsAr, hsR, hsAw, hsW, hsB, prevArV, prevAwV, prevWV, rPend, bPend, awGot, wGot} = '0;
    {prevArA, prevAwA, rAddr, wrAddr} = '0;
    prevWD = '0; wrData = '0;
    {arCnt, awCnt, wCnt, rWait, bWait} = '0;
    forever begin
      @(negedge clk);
      if (!rstN) begin
        {arReady, rValid, awReady, wReady, bValid} = '0;
        {hsAr, hsR, hsAw, hsW, hsB, prevArV, prevAwV, prevWV, rPend, bPend, awGot, wGot} = '0;
        {arCnt, awCnt, wCnt, rWait, bWait} = '0;
        continue;
      end
      if (prevArV && !hsAr) begin
        checkOutput("arHeld", 64'(arValid), 64'd1);
        checkOutput("arAddrStable", 64'(arAddr), 64'(prevArA));
      end
      if (hsAr) checkOutput("arDrop", 64'(arValid), 64'd0);
      if (prevAwV && !hsAw) begin
        checkOutput("awHeld", 64'(awValid), 64'd1);
        checkOutput("awAddrStable", 64'(awAddr), 64'(prevAwA));
      end
      if (hsAw) checkOutput("awDrop", 64'(awValid), 64'd0);
      if (prevWV && !hsW) begin
        checkOutput("wHeld", 64'(wValid), 64'd1);
        checkOutput("wDataStable", wData, prevWD);
      end
      if (hsW) checkOutput("wDrop", 64'(wValid), 64'd0);

      if (hsAr) begin rPend = 1'b1; rWait = cfgRLat; arCnt = 0; end
      if (hsR) rValid = 1'b0;
      if (hsAw) begin awGot = 1'b1; awCnt = 0; end
      if (hsW) begin wGot = 1'b1; wCnt = 0; end
      if (awGot && wGot) begin
        dramMem[wrAddr] = wrData;
        bPend = 1'b1; bWait = cfgBLat; awGot = 1'b0; wGot = 1'b0;
      end
      if (hsB) bValid = 1'b0;

      if (arValid) arCnt++;
      if (awValid) awCnt++;
      if (wValid) wCnt++;
      arReady = (cfgArDly == 0) || (arValid && arCnt > cfgArDly);
      awReady = (cfgAwDly == 0) || (awValid && awCnt > cfgAwDly);
      wReady  = (cfgWDly == 0)  || (wValid && wCnt > cfgWDly);
      if (rPend) begin
        if (rWait == 0) begin
          rValid = 1'b1; rData = dramRead(rAddr); rResp = cfgRResp; rPend = 1'b0;
        end else rWait--;
      end
      if (bPend) begin
        if (bWait == 0) begin
          bValid = 1'b1; bResp = cfgBResp; bPend = 1'b0;
        end else bWait--;
      end

      #1;
      hsAr = arValid && arReady;
      hsR  = rValid && rReady;
      hsAw = awValid && awReady;
      hsW  = wValid && wReady;
      hsB  = bValid && bReady;
      if (hsAr) begin
        if (expArQ.size() == 0) failNow("unexpectedAr");
        else checkOutput("arAddr", 64'(arAddr), 64'(expArQ.pop_front()));
        rAddr = arAddr;
      end
      if (hsAw) begin
        if (expAwQ.size() == 0) failNow("unexpectedAw");
        else checkOutput("awAddr", 64'(awAddr), 64'(expAwQ.pop_front()));
        wrAddr = awAddr;
      end
      if (hsW) begin
        if (expWQ.size() == 0) failNow("unexpectedW");
        else checkOutput("wData", wData, expWQ.pop_front());
        wrData = wData;
      end
      prevArV = arValid; prevArA = arAddr;
      prevAwV = awValid; prevAwA = awAddr;
      prevWV  = wValid;  prevWD  = wData;
    end
  end

  // Response monitor: pops the scoreboard on every rsp_valid pulse.
  initial begin : monitor
    logic prevRsp;
    rsp_t e;
    prevRsp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rstN) begin prevRsp = 1'b0; continue; end
      if (prevRsp) checkOutput("reqReadyAfterRsp", 64'(reqReady), 64'd1);
      if (rspValid) begin
        if (scoreQ.size() == 0) failNow("unexpectedRsp");
        else begin
          e = scoreQ.pop_front();
          checkOutput("rspRdata", rspRdata, e.rdata);
          checkOutput("rspErr", 64'(rspErr), 64'(e.err));
          if (e.expCycle >= 0) checkOutput("rspLatency", 64'(posCount), 64'(e.expCycle));
        end
      end
      prevRsp = rspValid;
    end
  end

  task automatic applyStimulus(input logic wr, input logic [7:0] idx, input logic [63:0] wdata,
                               input logic [1:0] resp, input logic chkLat);
    int n;
    logic [16:0] a;
    rsp_t e;
    n = 0;
    @(negedge clk);
    while (!reqReady && n < 500) begin @(negedge clk); n++; end
    if (!reqReady) begin failNow("reqReadyTimeout"); return; end
    a = modelAddr(int'(idx));
    reqValid = 1'b1; reqWrite = wr; reqIdx = idx; reqWdata = wdata;
    e.err = (resp != 2'b00);
    e.expCycle = chkLat ? posCount + 3 : -1;
    if (wr) begin
      refMem[a] = wdata;
      expAwQ.push_back(a);
      expWQ.push_back(wdata);
      cfgBResp = resp;
      e.rdata = lastRdata;
    end else begin
      e.rdata = refRead(a);
      lastRdata = e.rdata;
      expArQ.push_back(a);
      cfgRResp = resp;
    end
    scoreQ.push_back(e);
    @(posedge clk);
    #1;
    reqValid = 1'b0; reqWrite = 1'($urandom); reqIdx = 8'($urandom); reqWdata = {$urandom, $urandom};
  endtask

  task automatic waitIdle();
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!(reqReady && scoreQ.size() == 0) && n < 400);
    if (!(reqReady && scoreQ.size() == 0)) failNow("idleTimeout");
  endtask

  initial begin : watchdog
    #800000;
    failNow("watchdog");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin : driver
    logic [1:0] resp;
    int n;
    rstN = 1'b0; reqValid = 1'b0; reqWrite = 1'b0; reqIdx = '0; reqWdata = '0;
    #12;
    checkOutput("resetReqReady", 64'(reqReady), 64'd0);
    checkOutput("resetValids", 64'({arValid, awValid, wValid, rReady, bReady, rspValid, rspErr}), 64'd0);
    checkOutput("resetRdata", rspRdata, 64'd0);
    checkOutput("resetAddrs", 64'({arAddr, awAddr}), 64'd0);
    checkOutput("resetWData", wData, 64'd0);
    @(negedge clk); rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("reqReadyAfterReset", 64'(reqReady), 64'd1);

    // Known read data at record 5, then a write whose AW_READY lags W by four cycles.
    refMem[17'h10028] = 64'hDEAD_BEEF_0123_4567;
    dramMem[17'h10028] = 64'hDEAD_BEEF_0123_4567;
    applyStimulus(1'b0, 8'h05, 64'd0, 2'b00, 1'b1);
    waitIdle();
    cfgAwDly = 4;
    applyStimulus(1'b1, 8'hFF, 64'hA5A5, 2'b00, 1'b0);
    waitIdle();
    cfgAwDly = 0;

    // AR stalled for twenty cycles while a competing request is held on the core side.
    cfgArDly = 20;
    applyStimulus(1'b0, 8'h33, 64'd0, 2'b00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      reqValid = 1'b1; reqWrite = 1'b1; reqIdx = 8'($urandom);
      #2 checkOutput("reqReadyBusy", 64'(reqReady), 64'd0);
    end
    @(negedge clk); reqValid = 1'b0; cfgArDly = 0;
    waitIdle();

    // Error write followed by a clean read.
    applyStimulus(1'b1, 8'h10, 64'h1234_5678_9ABC_DEF0, 2'b10, 1'b0);
    applyStimulus(1'b0, 8'h10, 64'd0, 2'b00, 1'b0);
    waitIdle();

    // Stray R/B responses while idle must not be acknowledged.
    @(negedge clk);
    rValid = 1'b1; bValid = 1'b1; rResp = 2'b11; bResp = 2'b11;
    for (int i = 0; i < 3; i++) begin
      #2;
      checkOutput("strayReady", 64'({rReady, bReady}), 64'd0);
      checkOutput("strayIdle", 64'(reqReady), 64'd1);
      @(negedge clk);
    end
    rValid = 1'b0; bValid = 1'b0;

    // Reset while waiting on read data abandons the read.
    cfgRLat = 8;
    applyStimulus(1'b0, 8'($urandom), 64'd0, 2'b00, 1'b0);
    n = 0;
    do begin @(negedge clk); n++; end while (!rReady && n < 50);
    if (!rReady) failNow("rReadyTimeout");
    #2 rstN = 1'b0;
    #1;
    checkOutput("midResetReady", 64'({rReady, arValid, reqReady}), 64'd0);
    checkOutput("midResetRsp", 64'(rspValid), 64'd0);
    checkOutput("midResetRdata", rspRdata, 64'd0);
    scoreQ.delete(); expArQ.delete(); expAwQ.delete(); expWQ.delete();
    lastRdata = '0;
    cfgRLat = 0;
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(posedge clk); #1;
    checkOutput("reqReadyAfterMidReset", 64'(reqReady), 64'd1);
    applyStimulus(1'b0, 8'h05, 64'd0, 2'b00, 1'b0);
    waitIdle();

    // Randomised traffic with varied READY timing and response codes.
    for (int i = 0; i < 60; i++) begin
      cfgArDly = $urandom_range(0, 3); cfgAwDly = $urandom_range(0, 3);
      cfgWDly = $urandom_range(0, 3);  cfgRLat = $urandom_range(0, 3);
      cfgBLat = $urandom_range(0, 3);
      resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(1'($urandom), 8'($urandom), {$urandom, $urandom}, resp, 1'b0);
    end
    waitIdle();

    // Back-to-back with every READY high: fixed three-cycle latency.
    {cfgArDly, cfgAwDly, cfgWDly, cfgRLat, cfgBLat} = '0;
    for (int i = 0; i < 8; i++)
      applyStimulus(1'(i % 3 == 2), 8'($urandom), {$urandom, $urandom}, 2'b00, 1'b1);
    waitIdle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
